// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched 1-8 bit pattern MSB first onto x
// at a 2^k-clock bit period, with an idle-high guard bit and optional repeat.
module seq_pattern_tx #(
    parameter int DIVW = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]      pat_q, pat_d;
    logic [2:0]      len_q, len_d;
    logic [2:0]      k_q, k_d;
    logic [2:0]      idx_q, idx_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic            startPrev_q;
    logic            x_q, x_d;
    logic            busy_q, busy_d;
    logic            strobe_q, strobe_d;
    logic            done_q, done_d;
    logic [3:0]      count_q, count_d;

    logic            startEdge;
    logic [DIVW-1:0] lastCnt;
    logic            atLast;

    assign startEdge = uio_in[3] & ~startPrev_q;
    assign lastCnt   = DIVW'((32'd1 << k_q) - 32'd1);
    assign atLast    = (cnt_q == lastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            startPrev_q <= 1'b1;
            x_q         <= 1'b1;
            busy_q      <= 1'b0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            startPrev_q <= uio_in[3];
            x_q         <= x_d;
            busy_q      <= busy_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    // Outputs are derived from the next state so every output is registered
    // yet already reflects the new state in the cycle after the deciding edge.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        k_d     = k_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (startEdge) begin
                    pat_d   = ui_in;
                    len_d   = uio_in[2:0];
                    k_d     = uio_in[7:5];
                    idx_d   = uio_in[2:0];
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (atLast) begin
                    cnt_d = '0;
                    if (idx_q != 3'd0) begin
                        idx_d = idx_q - 3'd1;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            GAP: begin
                if (atLast) begin
                    cnt_d = '0;
                    if (uio_in[4]) begin
                        idx_d   = len_q;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        x_d      = (state_d == SEND) ? pat_d[idx_d] : 1'b1;
        busy_d   = (state_d != IDLE);
        strobe_d = (state_d == SEND) && (cnt_d == '0);
        done_d   = (state_q == SEND) && (state_d == GAP);
        count_d  = done_d ? count_q + 4'd1 : count_q;
    end

    assign uo_out = {count_q, done_q, strobe_q, busy_q, x_q};

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized self-checking bench for seq_pattern_tx; expected outputs come from
// a frame-position model (which bit, which cycle of the bit, gap or idle).
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui;
    logic [2:0] code;
    logic       startB;
    logic       repB;
    logic [2:0] kSel;
    logic [7:0] uio;
    logic [7:0] uo_out;

    int         total = 0;
    int         bad = 0;
    logic [3:0] tbCount = 4'd0;

    assign uio = {kSel, repB, startB, code};

    seq_pattern_tx #(.DIVW(7)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui),
        .uio_in (uio),
        .uo_out (uo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Expected output byte at cycle c (1-based after the accepting edge) of a
    // frame with pattern p, length L, period T and count cb before the frame.
    function automatic logic [7:0] expOut(input logic [7:0] p, input int L, input int T,
                                          input int c, input logic [3:0] cb);
        int         n;
        logic [3:0] cn;
        if (c <= L * T) begin
            n = (c - 1) / T;
            return {cb, 1'b0, ((c - 1) % T) == 0, 1'b1, p[L - 1 - n]};
        end
        cn = cb + 4'd1;
        return {cn, (c == L * T + 1), 1'b0, 1'b1, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Creates a start edge; returns positioned in cycle 1 of the new frame.
    task automatic launch(input logic [7:0] p, input logic [2:0] cd, input logic [2:0] kk,
                          input logic rp);
        startB = 1'b0;
        tick();
        ui     = p;
        code   = cd;
        kSel   = kk;
        repB   = rp;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        ui     = 8'($urandom);
        code   = 3'($urandom);
        kSel   = 3'($urandom);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        launch(8'hC3, 3'd4, 3'd1, 1'b0);
        tick();
        tick();
        startB = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 8'h01) begin
            bad++;
            $display("[TB] FAIL reset_async got=%h want=%h", uo_out, 8'h01);
        end
        tbCount = 4'd0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (uo_out !== 8'h01) begin
                bad++;
                $display("[TB] FAIL reset_start_held i=%0d got=%h want=%h", i, uo_out, 8'h01);
            end
            tick();
        end
        launch(8'h01, 3'd0, 3'd0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            e = expOut(8'h01, 1, 1, c, tbCount);
            total++;
            if (uo_out !== e) begin
                bad++;
                $display("[TB] FAIL len1_frame c=%0d got=%h want=%h", c, uo_out, e);
            end
            tick();
        end
        tbCount++;
        total++;
        if (uo_out !== {tbCount, 4'b0001}) begin
            bad++;
            $display("[TB] FAIL len1_idle got=%h want=%h", uo_out, {tbCount, 4'b0001});
        end
    endtask

    task automatic test_detector();
        logic [7:0] e;
        launch(8'h03, 3'd2, 3'd0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            e = expOut(8'h03, 3, 1, c, tbCount);
            total++;
            if (uo_out !== e) begin
                bad++;
                $display("[TB] FAIL detector c=%0d got=%h want=%h", c, uo_out, e);
            end
            tick();
        end
        tbCount++;
        total++;
        if (uo_out !== {tbCount, 4'b0001}) begin
            bad++;
            $display("[TB] FAIL detector_idle got=%h want=%h", uo_out, {tbCount, 4'b0001});
        end
    endtask

    task automatic test_period();
        logic [7:0] e;
        launch(8'hA5, 3'd7, 3'd2, 1'b0);
        for (int c = 1; c <= 36; c++) begin
            e = expOut(8'hA5, 8, 4, c, tbCount);
            total++;
            if (uo_out !== e) begin
                bad++;
                $display("[TB] FAIL period c=%0d got=%h want=%h", c, uo_out, e);
            end
            tick();
        end
        tbCount++;
        total++;
        if (uo_out !== {tbCount, 4'b0001}) begin
            bad++;
            $display("[TB] FAIL period_idle got=%h want=%h", uo_out, {tbCount, 4'b0001});
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        logic [7:0] p;
        logic [2:0] cd;
        logic [2:0] kk;
        int         L;
        int         T;
        for (int f = 0; f < 6; f++) begin
            p  = 8'($urandom);
            cd = 3'($urandom_range(0, 7));
            kk = 3'($urandom_range(0, 3));
            L  = int'(cd) + 1;
            T  = 1 << kk;
            launch(p, cd, kk, 1'b0);
            for (int c = 1; c <= (L + 1) * T; c++) begin
                e = expOut(p, L, T, c, tbCount);
                total++;
                if (uo_out !== e) begin
                    bad++;
                    $display("[TB] FAIL random f=%0d p=%h L=%0d T=%0d c=%0d got=%h want=%h",
                             f, p, L, T, c, uo_out, e);
                end
                ui = 8'($urandom);
                tick();
            end
            tbCount++;
            total++;
            if (uo_out !== {tbCount, 4'b0001}) begin
                bad++;
                $display("[TB] FAIL random_idle f=%0d got=%h want=%h", f, uo_out, {tbCount, 4'b0001});
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] e;
        launch(8'hB4, 3'd5, 3'd1, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            e = expOut(8'hB4, 6, 2, c, tbCount);
            total++;
            if (uo_out !== e) begin
                bad++;
                $display("[TB] FAIL ignored_start c=%0d got=%h want=%h", c, uo_out, e);
            end
            if (c == 2) begin
                startB = 1'b1;
                ui     = 8'hFF;
            end
            tick();
        end
        tbCount++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (uo_out !== {tbCount, 4'b0001}) begin
                bad++;
                $display("[TB] FAIL ignored_start_idle i=%0d got=%h want=%h", i, uo_out, {tbCount, 4'b0001});
            end
            tick();
        end
        startB = 1'b0;
    endtask

    task automatic test_repeat_wrap();
        logic [7:0] e;
        launch(8'h03, 3'd2, 3'd0, 1'b1);
        for (int f = 0; f < 17; f++) begin
            for (int c = 1; c <= 4; c++) begin
                e = expOut(8'h03, 3, 1, c, tbCount);
                total++;
                if (uo_out !== e) begin
                    bad++;
                    $display("[TB] FAIL repeat f=%0d c=%0d got=%h want=%h", f, c, uo_out, e);
                end
                ui = 8'($urandom);
                if (f == 16 && c == 2) repB = 1'b0;
                tick();
            end
            tbCount++;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (uo_out !== {tbCount, 4'b0001}) begin
                bad++;
                $display("[TB] FAIL repeat_stop i=%0d got=%h want=%h", i, uo_out, {tbCount, 4'b0001});
            end
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e;
        launch(8'h5A, 3'd3, 3'd3, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            e = expOut(8'h5A, 4, 8, c, tbCount);
            total++;
            if (uo_out !== e) begin
                bad++;
                $display("[TB] FAIL midframe c=%0d got=%h want=%h", c, uo_out, e);
            end
            if (c == 10) break;
            tick();
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 8'h01) begin
            bad++;
            $display("[TB] FAIL midframe_reset got=%h want=%h", uo_out, 8'h01);
        end
        tbCount = 4'd0;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (uo_out !== 8'h01) begin
            bad++;
            $display("[TB] FAIL midframe_after got=%h want=%h", uo_out, 8'h01);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ui     = 8'h00;
        code   = 3'd0;
        startB = 1'b0;
        repB   = 1'b0;
        kSel   = 3'd0;
        tick();
        tick();
        rst_n = 1'b1;
        total++;
        if (uo_out !== 8'h01) begin
            bad++;
            $display("[TB] FAIL power_on got=%h want=%h", uo_out, 8'h01);
        end
        test_reset();
        test_detector();
        test_period();
        test_random();
        test_ignored_start();
        test_repeat_wrap();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the transmit end of the team's single-bit sequence-detection link. It shifts a programmable 1–8 bit pattern, MSB first, onto a serial line `x` at a selectable bit period. Frames can be single-shot or repeating, with an idle-high guard bit between frames. Its `uo_out[0]` connects directly to a detector's serial input, and the frame counter drives the board display nibble.

## Interface
- `DIVW`, default 7: width of the bit-period counter. It must satisfy 2^DIVW ≥ 2^7 so that k=7 is reachable.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ui_in`, in, 8: pattern byte P.
- `uio_in`, in, 8:
  - [2:0]: length code; length L = code+1, range 1..8.
  - [3]: start, level input; acts on its rising edge.
  - [4]: repeat.
  - [7:5]: period select k; bit period T = 2^k clocks.
- `uo_out`, out, 8:
  - [0]: x, serial out.
  - [1]: busy.
  - [2]: bit_strobe.
  - [3]: done.
  - [7:4]: frame count mod 16.

## Operation
- All outputs are registered.
- Reset values:
  - x=1, busy=0, bit_strobe=0, done=0, count=0, state=IDLE.
  - Start-history register start_q=1, so a start held high through reset release does not trigger.
- Start edge: `uio_in[3]`=1 and start_q=0, sampled on a clock edge. start_q <= `uio_in[3]` on every cycle.
- IDLE:
  - x=1, busy=0.
  - On a start edge, latch P, L and k into internal registers. Load the bit index with L-1, clear the period counter, and go to SEND.
  - `ui_in` and `uio_in[2:0]`/[7:5] are don't-care outside that edge.
- SEND:
  - x = Platched[idx], busy=1.
  - The period counter counts 0..T-1.
  - When the counter reaches T-1:
    - If idx>0: idx decrements and the counter clears.
    - If idx=0: go to GAP, the counter clears, done pulses, and count increments.
- GAP:
  - x=1, busy=1, duration T clocks.
  - At the end of GAP, sample live `uio_in[4]`:
    - If 1: reload idx=L-1 from the latched values and return to SEND. Latched P/L/k are reused and live `ui_in` is ignored.
    - If 0: go to IDLE.
- bit_strobe: 1 for exactly the first clock of each SEND bit (counter==0 in SEND). 0 in GAP and IDLE.
- done: 1 for exactly the first clock of GAP.
- count: 4-bit, increments by 1 per completed frame, same cycle as done. Wraps 15 -> 0. Cleared only by reset.
- Start edges while busy=1 (SEND or GAP) are ignored and not queued. A new edge is required once IDLE is reached.
- Clearing repeat mid-frame has no effect until the end-of-GAP sample.
- Reset is asserted asynchronously at any point (mid-bit, GAP): outputs go to reset values immediately and the frame is abandoned. count clears even if a frame was partially sent.
- L=1: a single bit P[0], then GAP.

## Timing
- Call E0 the clock edge that samples the start edge.
- First data bit P[L-1] is on x, with busy=1 and bit_strobe=1, in the cycle after E0. Latency is 1 clock.
- Bit n (n=0..L-1) occupies cycles 1+n·T .. (n+1)·T after E0.
- GAP occupies cycles L·T+1 .. (L+1)·T. done and the updated count appear at cycle L·T+1.
- Non-repeat: busy=0 from cycle (L+1)·T+1. The earliest next accepted start edge is sampled at the edge that ends that cycle.
- Repeat: the next frame's first bit is at cycle (L+1)·T+1. The frame-to-frame period is (L+1)·T.
- The period counter is DIVW bits and compares against 2^k-1. For k=0, every SEND cycle is a new bit, with bit_strobe continuously 1.

## Test plan
- Reset: drive `rst_n`=0 mid-run with start high; release with start still high -> `uo_out`=8'h01; no frame starts until start goes low then high.
- Detector pattern "011": P=8'h03, code=2, k=0, repeat=0, pulse start -> cycles 1..3 give x=0,1,1 with bit_strobe=1. Cycle 4: x=1, done=1, count=1. Cycle 5: busy=0, `uo_out`=8'h11.
- Bit period: P=8'hA5, code=7, k=2 -> each bit held 4 clocks, sequence 1,0,1,0,0,1,0,1. bit_strobe only every 4th cycle. done at cycle 33, busy low at cycle 37.
- Repeat and wrap: P=8'h03, code=2, k=0, repeat=1 -> frames every 4 cycles. count runs 1..15, then 0 on the 16th done. Clearing repeat during a frame -> IDLE after that frame's GAP.
- Ignored start: a second start edge at cycle 2 of a frame, and new `ui_in`=8'hFF -> the frame completes with the original bits, with no second frame.
- Reset mid-frame: assert `rst_n`=0 during bit 1 of a k=3 frame -> x=1, busy=0, count=0 immediately, without waiting for a clock edge.
